// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 16x-oversampling UART receiver.
//   state_e    - receiver FSM states
//   OVERSAMPLE - ticks per bit
//   SAMPLE_*   - tick-counter values at which rx is sampled for the majority vote
//   maj3       - 2-of-3 majority helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk - system clock
//   rst - synchronous active-high reset; both stages reset to 1 (idle line)
//   d   - asynchronous input
//   q   - synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_16x.sv
// uart_rx_16x: UART receiver with 16x oversampling and 3-sample majority vote.
//   clk, rst   - system clock, synchronous active-high reset
//   tick_16x   - one-clk enable at 16x the baud rate; FSM and counter step only on it
//   rx         - asynchronous serial line, idle high
//   data_out   - last good data word (LSB received first), held until the next good frame
//   data_valid - one-clk pulse when data_out is updated
//   parity_err - one-clk pulse with data_valid when the parity bit mismatched
//   frame_err  - one-clk pulse when the stop bit is sampled low
//   busy       - high whenever the FSM is not IDLE
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  logic rx_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  state_e               state_q,    state_d;
  logic [3:0]           cnt_q,      cnt_d;
  logic [2:0]           bit_idx_q,  bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q,    shreg_d;
  logic [1:0]           samp_q,     samp_d;
  logic                 perr_q,     perr_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 dv_q,       dv_d;
  logic                 pe_q,       pe_d;
  logic                 fe_q,       fe_d;
  logic                 maj;
  logic                 at_hi;
  logic                 at_wrap;

  // Samples at cnt 7 and 8 are held; the vote is taken live at cnt 9.
  assign maj     = maj3(samp_q[0], samp_q[1], rx_s);
  assign at_hi   = (cnt_q == 4'(SAMPLE_HI));
  assign at_wrap = (cnt_q == 4'(OVERSAMPLE - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    samp_d     = samp_q;
    perr_d     = perr_q;
    data_out_d = data_out_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    fe_d       = 1'b0;

    if (tick_16x) begin
      if (state_q != IDLE) cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(SAMPLE_LO))  samp_d[0] = rx_s;
      if (cnt_q == 4'(SAMPLE_MID)) samp_d[1] = rx_s;

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = 4'd0;
          end
        end
        START: begin
          if (at_hi && maj) begin
            // glitch shorter than half a bit: drop it silently
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (at_wrap) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
        DATA: begin
          if (at_hi) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          if (at_wrap) begin
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              state_d   = (PARITY_EN != 0) ? PARITY : STOP;
              bit_idx_d = 3'd0;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (at_hi)   perr_d  = maj ^ (^shreg_q) ^ (PARITY_ODD != 0);
          if (at_wrap) state_d = STOP;
        end
        STOP: begin
          // Leave mid-stop-bit so the next start edge is caught right away.
          if (at_hi) begin
            cnt_d = 4'd0;
            if (maj) begin
              data_out_d = shreg_q;
              dv_d       = 1'b1;
              pe_d       = (PARITY_EN != 0) && perr_q;
              state_d    = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          cnt_d = 4'd0;
          if (rx_s) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      bit_idx_q  <= 3'd0;
      shreg_q    <= '0;
      samp_q     <= 2'b00;
      perr_q     <= 1'b0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      samp_q     <= samp_d;
      perr_q     <= perr_d;
      data_out_q <= data_out_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/uart_rx_16x.md
UART_RX_16X -- requirements
Module: uart_rx_16x

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..8), LSB first.
REQ-002 SHALL have parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-003 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tick_16x  input  1  one-clk pulse at 16x baud rate, from the baud divider.
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port data_out  output  DATA_BITS  last received data word.
REQ-009 SHALL have port data_valid  output  1  one-clk pulse: data_out updated.
REQ-010 SHALL have port parity_err  output  1  one-clk pulse, coincident with data_valid, parity mismatch.
REQ-011 SHALL have port frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s); the synchronizer's reset value is 1.
REQ-014 SHALL advance the FSM and the 4-bit tick counter (cnt) only on clk edges where tick_16x=1.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-016 IDLE: on a tick with rx_s=0, SHALL go to START with cnt=0.
REQ-017 All non-IDLE bit states: cnt SHALL increment per tick and wrap 15->0. The bit value SHALL be the majority of rx_s at cnt=7,8,9.
REQ-018 START: at cnt=9, a majority of 1 SHALL be a false start and return to IDLE with no outputs. Otherwise the FSM SHALL go to DATA at the wrap.
REQ-019 DATA: the bit SHALL be shifted in at cnt=9. After DATA_BITS bits, the FSM SHALL go at the wrap to PARITY if PARITY_EN=1, else to STOP.
REQ-020 PARITY: the bit SHALL be sampled at cnt=9 and compared with the XOR of the data, inverted when PARITY_ODD. The FSM SHALL go to STOP at the wrap.
REQ-021 STOP, at cnt=9 with majority 1: data_out SHALL load the shift register, data_valid SHALL pulse, parity_err SHALL pulse if there is a mismatch, and the FSM SHALL go to IDLE immediately (it does not wait for the wrap).
REQ-022 STOP, at cnt=9 with majority 0: frame_err SHALL pulse, data_out and data_valid SHALL be unchanged, and the FSM SHALL go to WAIT_IDLE.
REQ-023 WAIT_IDLE: SHALL stay until a tick with rx_s=1, then go to IDLE; a line held low (break) produces exactly one frame_err.
REQ-024 Pulse outputs SHALL be registered and high exactly one clk cycle after the deciding tick edge.
REQ-025 data_out SHALL hold its value until the next valid frame.
REQ-026 With no consumer handshake, the next valid frame SHALL overwrite data_out.
REQ-027 tick_16x held low SHALL freeze the FSM and counters indefinitely without error.
REQ-028 A start edge SHALL be accepted on the first tick after the STOP-to-IDLE transition, so back-to-back frames are supported.

Reset
REQ-029 On rst=1 at a clk edge, the following SHALL apply: state=IDLE, cnt=0, bit index=0, shift register=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, synchronizer=1.
REQ-030 rst SHALL take priority over tick_16x. A reset mid-frame SHALL discard the partial frame and emit no pulse.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum, OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8 and SAMPLE_HI=9.
REQ-032 The 2-flop synchronizer SHALL be a sub-module sync_2ff (reset value 1). The FSM, counters and majority vote SHALL reside in uart_rx_16x.
REQ-033 There SHALL be no other clocks and no asynchronous logic.

Verification (bench: tick_16x every 4 clk; 64 clk/bit)
REQ-034 Send 0x55, 8N1 -> one data_valid with data_out=0x55 during the stop bit, parity_err=0, frame_err=0.
REQ-035 Pull rx low for 5 ticks, then high -> busy rises then falls, no pulses, state returns to IDLE.
REQ-036 Send 0xA3 with stop bit forced low, then hold rx low for 3 bit times -> exactly one frame_err, no data_valid, busy stays high until rx goes high.
REQ-037 PARITY_EN=1, even parity: send 0xA5 with parity bit 1 -> data_valid with data_out=0xA5 and parity_err=1. Send again with parity bit 0 -> parity_err=0.
REQ-038 Send 0x00 and 0xFF back-to-back with zero idle gap -> two data_valid pulses, 0x00 then 0xFF, 640 clk apart.
REQ-039 Assert rst for 1 clk at the 4th data bit of 0x3C, then send 0x81 -> no pulse for the first frame, then data_valid with data_out=0x81.
